// File: rtl/tiny32_bus_pkg.sv
// tiny32_bus_pkg: shared encodings and request detection for the tiny32 native bus
package tiny32_bus_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
    localparam logic [3:0] NWR_IDLE = 4'hF;
    // A master requests when it strobes a read, any write byte, or both at once
    function automatic logic is_req(input logic nrd, input logic [3:0] nwr);
        return !nrd || (nwr != NWR_IDLE);
    endfunction
endpackage

// File: rtl/tiny32_bus_arbiter_if.sv
// tiny32_bus_arbiter_if: one tiny32 native bus link between a master and a slave
interface tiny32_bus_arbiter_if;
    logic [31:0] address;
    logic [31:0] data_out;
    logic        nrd;
    logic [3:0]  nwr;
    logic [31:0] data_in;
    logic        ready;
    modport master (output address, data_out, nrd, nwr, input data_in, ready);
    modport slave (input address, data_out, nrd, nwr, output data_in, ready);
endinterface

// File: rtl/tiny32_rr_arbiter.sv
// tiny32_rr_arbiter: two-way winner select, fixed M0 priority or round-robin on ties
module tiny32_rr_arbiter (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    input  logic fixed_priority,
    output logic winner
);
    // On a tie the master not granted last wins unless M0 is pinned to priority
    assign winner = (req0 && req1) ? (!fixed_priority && !last_grant) : (!req0 && req1);
endmodule

// File: rtl/tiny32_bus_arbiter.sv
// tiny32_bus_arbiter: shares one registered slave port between two tiny32 masters with a timeout watchdog
module tiny32_bus_arbiter
    import tiny32_bus_pkg::*;
#(
    parameter bit          FIXED_PRIORITY = 1'b0,
    parameter int          TIMEOUT        = 16,
    parameter logic [31:0] ERR_DATA       = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    tiny32_bus_arbiter_if.slave   m0,
    tiny32_bus_arbiter_if.slave   m1,
    tiny32_bus_arbiter_if.master  s,
    output logic                  bus_error,
    output logic                  grant
);
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_t     state;
    logic       rr_ptr;
    logic [7:0] counter;
    logic       req0;
    logic       req1;
    logic       winner;
    logic       finish;
    assign req0 = is_req(m0.nrd, m0.nwr);
    assign req1 = is_req(m1.nrd, m1.nwr);
    assign finish = s.ready || (counter == LAST);
    assign m0.ready = !req0 || (state == DONE && !grant);
    assign m1.ready = !req1 || (state == DONE && grant);
    tiny32_rr_arbiter u_arb (
        .req0           (req0),
        .req1           (req1),
        .last_grant     (rr_ptr),
        .fixed_priority (FIXED_PRIORITY),
        .winner         (winner)
    );
    // Transaction FSM: latch the winner onto the slave port, then wait for s.ready or the watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b1;
            rr_ptr     <= 1'b1;
            counter    <= 8'd0;
            s.address  <= 32'd0;
            s.data_out <= 32'd0;
            s.nrd      <= 1'b1;
            s.nwr      <= NWR_IDLE;
            m0.data_in <= 32'd0;
            m1.data_in <= 32'd0;
            bus_error  <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                IDLE: if (req0 || req1) begin
                    s.address  <= winner ? m1.address : m0.address;
                    s.data_out <= winner ? m1.data_out : m0.data_out;
                    s.nrd      <= winner ? m1.nrd : m0.nrd;
                    s.nwr      <= winner ? m1.nwr : m0.nwr;
                    grant      <= winner;
                    if (req0 && req1) rr_ptr <= winner;
                    counter    <= 8'd0;
                    state      <= ACCESS;
                end
                ACCESS: begin
                    counter <= counter + 8'd1;
                    if (finish) begin
                        if (grant) m1.data_in <= s.ready ? s.data_in : ERR_DATA;
                        else m0.data_in <= s.ready ? s.data_in : ERR_DATA;
                        bus_error <= !s.ready;
                        s.nrd     <= 1'b1;
                        s.nwr     <= NWR_IDLE;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tiny32_bus_arbiter.sv
// tb_tiny32_bus_arbiter: randomized transaction-level check of the two-master bus arbiter
module tb_tiny32_bus_arbiter;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] ERR     = 32'hFFFFFFFF;
    typedef struct {
        logic        nrd;
        logic [3:0]  nwr;
        logic [31:0] addr;
        logic [31:0] dout;
    } mreq_t;
    localparam mreq_t IDLE_R = '{1'b1, 4'hF, 32'h0, 32'h0};
    logic clk = 1'b0;
    logic reset;
    logic bus_error;
    logic grant;
    logic fp_err;
    logic fp_grant;
    int checks = 0;
    int errors = 0;
    mreq_t drv [2];
    logic sl_ready;
    logic [31:0] sl_data;
    logic model_rr;
    logic [31:0] exp_d [2];
    logic [1:0] rdy;
    logic [31:0] din [2];
    always #5 clk = ~clk;
    tiny32_bus_arbiter_if m0 ();
    tiny32_bus_arbiter_if m1 ();
    tiny32_bus_arbiter_if s ();
    tiny32_bus_arbiter_if f0 ();
    tiny32_bus_arbiter_if f1 ();
    tiny32_bus_arbiter_if fs ();
    assign m0.address  = drv[0].addr;
    assign m0.data_out = drv[0].dout;
    assign m0.nrd      = drv[0].nrd;
    assign m0.nwr      = drv[0].nwr;
    assign m1.address  = drv[1].addr;
    assign m1.data_out = drv[1].dout;
    assign m1.nrd      = drv[1].nrd;
    assign m1.nwr      = drv[1].nwr;
    assign s.ready     = sl_ready;
    assign s.data_in   = sl_data;
    assign rdy         = {m1.ready, m0.ready};
    assign din[0]      = m0.data_in;
    assign din[1]      = m1.data_in;
    tiny32_bus_arbiter #(.FIXED_PRIORITY(1'b0), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR)) dut (
        .clk(clk), .reset(reset), .m0(m0), .m1(m1), .s(s), .bus_error(bus_error), .grant(grant)
    );
    tiny32_bus_arbiter #(.FIXED_PRIORITY(1'b1), .TIMEOUT(4), .ERR_DATA(ERR)) dut_fp (
        .clk(clk), .reset(reset), .m0(f0), .m1(f1), .s(fs), .bus_error(fp_err), .grant(fp_grant)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic wants(input mreq_t r);
        return !r.nrd || r.nwr != 4'hF;
    endfunction
    function automatic mreq_t rnd_req();
        mreq_t r;
        r.nrd = 1'($urandom);
        r.nwr = 4'($urandom);
        r.addr = $urandom;
        r.dout = $urandom;
        if (r.nrd && r.nwr == 4'hF) r.nrd = 1'b0;
        return r;
    endfunction
    // One whole transaction: the slave answers after `delay` wait cycles, or never if delay >= TIMEOUT
    task automatic txn(input mreq_t r0, input mreq_t r1, input int delay, input logic [31:0] rdata);
        mreq_t r [2];
        logic req [2];
        int win, los, ncyc;
        logic err;
        r[0] = r0;
        r[1] = r1;
        req[0] = wants(r0);
        req[1] = wants(r1);
        @(negedge clk);
        drv[0] = r0;
        drv[1] = r1;
        sl_ready = 1'b0;
        sl_data = rdata;
        win = (req[0] && req[1]) ? int'(!model_rr) : int'(req[1]);
        if (req[0] && req[1]) model_rr = win[0];
        los = 1 - win;
        err = delay >= TIMEOUT;
        ncyc = err ? TIMEOUT : delay + 1;
        exp_d[win] = err ? ERR : rdata;
        #1;
        check("req_stall", 32'(rdy[win]), 32'd0);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            check("s_addr", s.address, r[win].addr);
            check("s_nrd", 32'(s.nrd), 32'(r[win].nrd));
            check("s_nwr", 32'(s.nwr), 32'(r[win].nwr));
            check("grant", 32'(grant), 32'(win));
            check("win_ready_low", 32'(rdy[win]), 32'd0);
            check("other_ready", 32'(rdy[los]), 32'(!req[los]));
            check("no_err_early", 32'(bus_error), 32'd0);
            if (k == 1) begin
                check("s_dout", s.data_out, r[win].dout);
                drv[win].addr = ~r[win].addr;
                drv[win].dout = ~r[win].dout;
            end
            sl_ready = (k - 1 == delay);
        end
        @(negedge clk);
        check("done_ready", 32'(rdy[win]), 32'd1);
        check("done_data", din[win], exp_d[win]);
        check("other_data", din[los], exp_d[los]);
        check("bus_error", 32'(bus_error), 32'(err));
        check("strobe_rel", {27'd0, s.nrd, s.nwr}, 32'h1F);
        check("done_other_ready", 32'(rdy[los]), 32'(!req[los]));
        drv[0] = IDLE_R;
        drv[1] = IDLE_R;
        sl_ready = 1'b0;
        @(negedge clk);
        check("err_pulse", 32'(bus_error), 32'd0);
        check("idle_ready", 32'(rdy), 32'd3);
    endtask
    initial begin
        mreq_t a, b;
        reset = 1'b1;
        drv[0] = IDLE_R;
        drv[1] = IDLE_R;
        sl_ready = 1'b0;
        sl_data = 32'd0;
        f0.nrd = 1'b1; f0.nwr = 4'hF; f0.address = 32'd0; f0.data_out = 32'd0;
        f1.nrd = 1'b1; f1.nwr = 4'hF; f1.address = 32'd0; f1.data_out = 32'd0;
        fs.ready = 1'b1; fs.data_in = 32'h12345678;
        model_rr = 1'b1;
        exp_d[0] = 32'd0;
        exp_d[1] = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_nrd", 32'(s.nrd), 32'd1);
        check("rst_nwr", 32'(s.nwr), 32'hF);
        check("rst_addr", s.address, 32'd0);
        check("rst_dout", s.data_out, 32'd0);
        check("rst_grant", 32'(grant), 32'd1);
        check("rst_err", 32'(bus_error), 32'd0);
        check("rst_din0", m0.data_in, 32'd0);
        check("rst_din1", m1.data_in, 32'd0);
        check("rst_ready", 32'(rdy), 32'd3);
        txn('{1'b0, 4'hF, 32'h100, 32'h0}, IDLE_R, 0, 32'hDEADBEEF);
        a = '{1'b1, 4'h0, 32'h200, 32'h11111111};
        b = '{1'b1, 4'h3, 32'h300, 32'h22222222};
        repeat (3) txn(a, b, 1, 32'h0BADF00D);
        txn(IDLE_R, '{1'b0, 4'hF, 32'h400, 32'h0}, 255, 32'h55555555);
        txn('{1'b0, 4'h5, 32'h500, 32'h3}, IDLE_R, TIMEOUT - 1, 32'hCAFE0001);
        txn('{1'b0, 4'hF, 32'h600, 32'h0}, IDLE_R, 40, 32'h0);
        @(negedge clk);
        drv[0] = '{1'b0, 4'hF, 32'h700, 32'h0};
        repeat (2) @(negedge clk);
        check("pre_rst_nrd", 32'(s.nrd), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("arst_nrd", 32'(s.nrd), 32'd1);
        check("arst_nwr", 32'(s.nwr), 32'hF);
        check("arst_grant", 32'(grant), 32'd1);
        check("arst_err", 32'(bus_error), 32'd0);
        check("arst_no_ready", 32'(m0.ready), 32'd0);
        check("arst_din0", m0.data_in, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drv[0] = IDLE_R;
        model_rr = 1'b1;
        exp_d[0] = 32'd0;
        exp_d[1] = 32'd0;
        for (int n = 0; n < 40; n++) begin
            int m;
            m = $urandom_range(1, 3);
            a = m[0] ? rnd_req() : IDLE_R;
            b = m[1] ? rnd_req() : IDLE_R;
            txn(a, b, $urandom_range(0, 20), $urandom);
        end
        @(negedge clk);
        f0.nrd = 1'b0; f0.address = 32'hA0;
        f1.nwr = 4'h0; f1.address = 32'hB0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("fp_m1_wait", 32'(f1.ready), 32'd0);
            check("fp_grant_m0", 32'(fp_grant), 32'd0);
        end
        for (int i = 0; i < 4 && !f0.ready; i++) @(negedge clk);
        check("fp_m0_done", 32'(f0.ready), 32'd1);
        f0.nrd = 1'b1;
        repeat (2) @(negedge clk);
        check("fp_grant_m1", 32'(fp_grant), 32'd1);
        check("fp_s_addr", fs.address, 32'hB0);
        check("fp_s_nwr", 32'(fs.nwr), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tiny32_bus_arbiter.md
Name: tiny32_bus_arbiter

Overview:
- Shares one memory/peripheral port between two bus masters: M0 is the tiny32 core, M1 is a DMA/debug requester.
- Both masters use the core's native bus: active-low nrd, active-low byte strobes nwr[3:0], and a ready handshake.
- Arbitration is round-robin (or fixed M0 priority) and registers each transaction toward the slave.
- A timeout watchdog completes hung accesses and flags a bus error.

Parameters:
- FIXED_PRIORITY, 0, 1 = M0 always wins a tie; 0 = round-robin, where the master not granted last wins a tie.
- TIMEOUT, 16, maximum ACCESS cycles before a forced completion (range 2..255).
- ERR_DATA, 32'hFFFFFFFF, read data returned on timeout.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- m0_address  in  32  M0 address
- m0_data_out  in  32  M0 write data
- m0_nrd  in  1  M0 read strobe, active low
- m0_nwr  in  4  M0 byte write strobes, active low
- m0_data_in  out  32  read data to M0
- m0_ready  out  1  M0 may advance
- m1_address, m1_data_out, m1_nrd, m1_nwr, m1_data_in, m1_ready: same as M0, for M1
- s_address  out  32  registered slave address
- s_data_out  out  32  registered slave write data
- s_nrd  out  1  slave read strobe, active low
- s_nwr  out  4  slave byte strobes, active low
- s_data_in  in  32  slave read data
- s_ready  in  1  slave completion, sampled in ACCESS
- bus_error  out  1  one-cycle pulse on timeout
- grant  out  1  owner of the current or last transaction (0 = M0, 1 = M1)

Behaviour:
- Request: mN_req = !mN_nrd | (mN_nwr != 4'b1111). A request with both a read and a write is legal and forwarded unchanged.
- mN_ready is combinational: !mN_req | (state==DONE & grant==N). An idle master is never stalled; a requesting master sees ready low until its DONE cycle.
- Reset values:
  - state=IDLE, grant=1 (so the first round-robin tie goes to M0)
  - s_nrd=1, s_nwr=4'hF, s_address=0, s_data_out=0
  - mN_data_in=0, bus_error=0, counter=0
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Request present: choose the winner (single requester wins; tie resolved by FIXED_PRIORITY / round-robin).
  - Register the winner's address, data_out, nrd and nwr onto s_*; set grant; clear counter; go to ACCESS.
- ACCESS:
  - s_* strobes are held stable; counter increments each cycle.
  - s_ready=1: capture s_data_in into the granted mN_data_in (even for writes); deassert s strobes; go to DONE.
  - Otherwise, when counter==TIMEOUT-1: load ERR_DATA into mN_data_in, pulse bus_error, deassert s strobes, go to DONE.
  - If s_ready and timeout coincide, the s_ready completion wins and there is no error.
- DONE: one cycle with granted mN_ready=1; next state IDLE.
- Latency: request in cycle T → s strobes in T+1 → with s_ready in T+1, mN_ready in T+2. Minimum 3 cycles per transaction.
- Back-to-back:
  - A request still held after DONE is arbitrated as a new transaction.
  - Masters must drop or change the request after their ready cycle.
  - The round-robin pointer flips only on a contested grant.
- The non-granted master's mN_data_in holds its last value.
- Changes to a granted master's inputs during ACCESS are ignored, because the inputs were registered.
- Reset asserted mid-transaction: immediate return to reset values, strobes released asynchronously; no completion is reported.
- counter width: 8 bits; it does not wrap because TIMEOUT ≤ 255.

Decomposition:
- Shared package (tiny32_bus_pkg):
  - state encoding constants IDLE=0, ACCESS=1, DONE=2
  - NWR_IDLE = 4'hF
  - the request-detect function
- Sub-module tiny32_rr_arbiter:
  - inputs: two request bits, the last-grant pointer and FIXED_PRIORITY
  - output: winner index
  - purely combinational, so it can be reused for the interrupt/DMA channels.

Test Plan:
- Single M0 read, address 0x100, slave returns 0xDEADBEEF with s_ready on the first ACCESS cycle → s_nrd low exactly 1 cycle, m0_ready high in cycle T+2, m0_data_in=0xDEADBEEF, grant=0.
- Simultaneous M0 and M1 write requests, round-robin, after reset → M0 served first (s_nwr=m0_nwr); M1 served next (s_address=m1_address); then repeat the tie → M0 wins again.
- FIXED_PRIORITY=1 with M0 requesting continuously and M1 waiting → M1 never granted while M0 requests; once M0 idles, M1 is granted within 1 cycle.
- Slave never asserts s_ready, TIMEOUT=16 → strobes held for 16 cycles, then bus_error pulses once, m1_data_in=0xFFFFFFFF, m1_ready pulses one cycle.
- Idle master: M1 has no request while M0 is stalled in ACCESS → m1_ready stays 1 throughout.
- Reset asserted in ACCESS with s_ready low → s_nrd=1 and s_nwr=4'hF immediately (asynchronously), state IDLE, no mN_ready pulse, no bus_error.
